// File: rtl/bsg_circular_ptr_pkg.sv
// bsg_circular_ptr_pkg: shared sizing helpers for circular pointer blocks
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_circular_ptr_pkg;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bsg_circular_ptr.sv
// bsg_circular_ptr: modulo-slots_p pointer advanced by add_i every cycle
module bsg_circular_ptr
    import bsg_circular_ptr_pkg::*;
#(
    parameter int slots_p = 16,
    parameter int max_add_p = 1,
    localparam int ptr_width = `BSG_SAFE_CLOG2(slots_p),
    localparam int add_width = `BSG_SAFE_CLOG2(max_add_p + 1)
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [add_width-1:0] add_i,
    output logic [ptr_width-1:0] o,
    output logic [ptr_width-1:0] n_o
);

    if (slots_p < 2 || max_add_p < 1 || max_add_p >= slots_p) begin : g_bad_params
        $error("bsg_circular_ptr: need slots_p >= 2 and 1 <= max_add_p < slots_p");
    end

    if (is_pow2(slots_p)) begin : g_pow2
        assign n_o = o + ptr_width'(add_i);
    end else begin : g_mod
        localparam logic [ptr_width:0] slots_lp = (ptr_width + 1)'(slots_p);
        logic [ptr_width:0] sum;
        assign sum = {1'b0, o} + (ptr_width + 1)'(add_i);
        assign n_o = ptr_width'((sum >= slots_lp) ? sum - slots_lp : sum);
    end

    // Pointer register: clear on active-low reset, otherwise take the next value
    always_ff @(posedge clk) begin
        o <= !reset_i ? '0 : n_o;
    end

    if (((1 << add_width) - 1) > max_add_p) begin : g_add_chk
        // Increments beyond max_add_p are outside the sized range of the adder
        always_ff @(posedge clk) begin
            if (reset_i) assert (add_i <= add_width'(max_add_p));
        end
    end

endmodule

// File: tb/tb_bsg_circular_ptr.sv
// tb_bsg_circular_ptr: directed tables plus random stream against a modular-sum model
module tb_bsg_circular_ptr;

    typedef struct {
        bit rst_n;
        int add;
        bit chk_n;
        int exp_n;
        int exp_o;
    } vec_t;

    logic       clk;
    logic       rst16, rst6;
    logic [3:0] add16, o16, n16;
    logic [2:0] add6, o6, n6;
    int         checks, errors;

    bsg_circular_ptr #(.slots_p(16), .max_add_p(15)) dut16 (
        .clk(clk), .reset_i(rst16), .add_i(add16), .o(o16), .n_o(n16)
    );

    bsg_circular_ptr #(.slots_p(6), .max_add_p(5)) dut6 (
        .clk(clk), .reset_i(rst6), .add_i(add6), .o(o6), .n_o(n6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step16(input vec_t v, input int idx);
        @(negedge clk);
        rst16 = v.rst_n;
        add16 = 4'(v.add);
        #1;
        if (v.chk_n) check($sformatf("n16[%0d]", idx), n16, v.exp_n);
        @(posedge clk);
        #1;
        check($sformatf("o16[%0d]", idx), o16, v.exp_o);
    endtask

    task automatic step6(input vec_t v, input int idx);
        @(negedge clk);
        rst6 = v.rst_n;
        add6 = 3'(v.add);
        #1;
        if (v.chk_n) check($sformatf("n6[%0d]", idx), n6, v.exp_n);
        @(posedge clk);
        #1;
        check($sformatf("o6[%0d]", idx), o6, v.exp_o);
    endtask

    initial begin
        vec_t t16[11];
        vec_t t6[9];
        int   m16, m6;
        checks = 0;
        errors = 0;
        rst16 = 1'b0;
        rst6 = 1'b0;
        add16 = '0;
        add6 = '0;

        t16[0]  = '{0, 0,  0, 0,  0};
        t16[1]  = '{1, 3,  1, 3,  3};
        t16[2]  = '{1, 11, 1, 14, 14};
        t16[3]  = '{1, 5,  1, 3,  3};
        t16[4]  = '{1, 6,  1, 9,  9};
        t16[5]  = '{1, 0,  1, 9,  9};
        t16[6]  = '{1, 7,  1, 0,  0};
        t16[7]  = '{1, 7,  1, 7,  7};
        t16[8]  = '{0, 5,  1, 12, 0};
        t16[9]  = '{1, 2,  1, 2,  2};
        t16[10] = '{1, 15, 1, 1,  1};

        t6[0] = '{0, 0, 0, 0, 0};
        t6[1] = '{1, 4, 1, 4, 4};
        t6[2] = '{1, 3, 1, 1, 1};
        t6[3] = '{1, 4, 1, 5, 5};
        t6[4] = '{1, 1, 1, 0, 0};
        t6[5] = '{1, 2, 1, 2, 2};
        t6[6] = '{1, 3, 1, 5, 5};
        t6[7] = '{1, 0, 1, 5, 5};
        t6[8] = '{1, 5, 1, 4, 4};

        for (int i = 0; i < 11; i++) step16(t16[i], i);
        for (int i = 0; i < 9; i++) step6(t6[i], i);

        @(negedge clk);
        rst16 = 1'b0;
        rst6 = 1'b0;
        add16 = 4'd9;
        add6 = 3'd2;
        @(posedge clk);
        #1;
        check("rand_reset16", o16, 0);
        check("rand_reset6", o6, 0);
        m16 = 0;
        m6 = 0;
        for (int c = 0; c < 10000; c++) begin
            int a16, a6;
            a16 = $urandom_range(15, 0);
            a6 = $urandom_range(5, 0);
            @(negedge clk);
            rst16 = 1'b1;
            rst6 = 1'b1;
            add16 = 4'(a16);
            add6 = 3'(a6);
            m16 = (m16 + a16) % 16;
            m6 = (m6 + a6) % 6;
            #1;
            check("rand_n16", n16, m16);
            check("rand_n6", n6, m6);
            @(posedge clk);
            #1;
            check("rand_o16", o16, m16);
            check("rand_o6", o6, m6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_circular_ptr.md
BSG_CIRCULAR_PTR -- requirements
Module: bsg_circular_ptr

Interface
REQ-001 SHALL: parameter slots_p, default 16, number of pointer positions; legal range is 2 or more.
REQ-002 SHALL: parameter max_add_p, default 1, largest increment accepted per cycle; legal range is 1 to slots_p-1.
REQ-003 SHALL: local ptr_width = safe_clog2(slots_p) and add_width = safe_clog2(max_add_p+1), where safe_clog2 returns at least 1.
REQ-004 SHALL: port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-005 SHALL: port reset_i, input, 1 bit, synchronous active-low reset: reset is asserted when reset_i is 0 at a rising clk edge.
REQ-006 SHALL: port add_i, input, add_width bits, unsigned increment applied this cycle.
REQ-007 SHALL: port o, output, ptr_width bits, registered current pointer.
REQ-008 SHALL: port n_o, output, ptr_width bits, combinational next pointer.

Function
REQ-009 SHALL: n_o = (o + add_i) mod slots_p, computed combinationally from o and add_i with zero-cycle latency.
REQ-010 SHALL: o take the value of n_o at each rising clk edge while reset_i is 1.
REQ-011 SHALL: when slots_p is a power of two, compute n_o as (o + add_i) truncated to ptr_width bits, with no compare logic.
REQ-012 SHALL: when slots_p is not a power of two, compute the sum at ptr_width+1 bits; if sum >= slots_p, n_o = sum - slots_p, else n_o = sum.
REQ-013 SHALL: with add_i = 0, keep o and n_o equal to the current value (hold).
REQ-014 SHALL: with add_i = slots_p - o (mod slots_p), make n_o = 0; users rely on this to clear the pointer by adding the two's-complement negative.
REQ-015 SHALL: keep o in the range 0 to slots_p-1 at all times after reset.
REQ-016 SHALL: have no handshake; every cycle's add_i is consumed unconditionally.
REQ-017 SHALL: if add_i > max_add_p, produce undefined output; simulation-only assertion flags it (not synthesized).
REQ-018 SHALL: elaboration check reject max_add_p >= slots_p and slots_p < 2.

Reset
REQ-019 SHALL: load o with 0 at a rising edge with reset_i = 0, regardless of add_i.
REQ-020 SHALL: during reset, n_o still reflect o + add_i per REQ-009; only the register load is overridden.
REQ-021 SHALL: handle reset asserted mid-operation the same as power-on reset: o = 0 on the next edge and counting resumes from 0 on the first edge after reset_i returns to 1.
REQ-022 SHALL: contain no asynchronous reset logic.

Structure
REQ-023 SHALL: use the shared bsg defines safe-clog2 macro; the block needs no package typedefs or constants.
REQ-024 SHALL: be a single flat module with no sub-modules, using a generate branch to select between the power-of-two and non-power-of-two adder paths.
REQ-025 SHALL: be instantiable three times side by side (read, write and checkpoint pointers) with identical parameters, where slots_p = 2x or 4x the FIFO depth and max_add_p = slots_p - 1.

Verification
REQ-026 SHALL: bench run slots_p=16, max_add_p=15; hold reset_i=0 for one edge, then release -> o=0; drive add_i=3 -> n_o=3 in the same cycle and o=3 after the edge.
REQ-027 SHALL: bench cover wrap with slots_p=16: o=14, add_i=5 -> n_o=3, and o=3 next cycle.
REQ-028 SHALL: bench cover clear by negation with slots_p=16: o=9, add_i=7 -> n_o=0, and o=0 next cycle; separately, add_i=0 with o=9 holds o=9.
REQ-029 SHALL: bench cover non-power-of-two with slots_p=6, max_add_p=5: o=4, add_i=3 -> n_o=1; o=5, add_i=1 -> n_o=0; o=2, add_i=3 -> n_o=5.
REQ-030 SHALL: bench cover reset mid-operation: o=7, add_i=5, reset_i=0 at the edge -> o=0 while n_o showed 12 before the edge; after release, add_i=2 -> o=2.
REQ-031 SHALL: bench run a 10k-cycle random add_i in 0..max_add_p stream against a modular-sum reference model for both slots_p=16 and slots_p=6, checking o and n_o every cycle.
